// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bundle between the fetch sequencer and imem.
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: PC enable/select, single-outstanding imem handshake, F/D flush.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          F_pc_current,
    input  logic [1:0]           E_pc_src_sel,
    input  logic                 D_stall,
    fetch_ctrl_if.master         imem,
    output logic                 pc_en,
    output logic [1:0]           pc_sel,
    output logic [31:0]          F_instr,
    output logic [31:0]          F_instr_pc,
    output logic                 F_instr_valid,
    output logic                 FD_flush,
    output logic [CNT_WIDTH-1:0] perf_stall_cycles,
    output logic [CNT_WIDTH-1:0] perf_redirects
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        VALID = 3'd4
    } state_t;

    state_t state, state_nxt;
    logic   redirect;
    logic   capture;
    logic   consume;

    // Select code 11 is reserved and folds into sequential fetch.
    assign redirect = (state != IDLE) &&
                      ((E_pc_src_sel == 2'b01) || (E_pc_src_sel == 2'b10));

    assign imem.imem_addr = F_pc_current;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        imem.imem_req = 1'b0;
        pc_en         = 1'b0;
        pc_sel        = 2'b00;
        FD_flush      = 1'b0;
        capture       = 1'b0;
        consume       = 1'b0;

        if (redirect) begin
            pc_en    = 1'b1;
            pc_sel   = E_pc_src_sel;
            FD_flush = 1'b1;
        end

        case (state)
            IDLE: begin
                state_nxt = REQ;
            end
            REQ: begin
                imem.imem_req = 1'b1;
                if (imem.imem_gnt) begin
                    // A grant that coincides with a redirect fetched a stale address.
                    state_nxt = redirect ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (imem.imem_rsp_valid) begin
                    if (redirect) begin
                        state_nxt = REQ;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = VALID;
                    end
                end else if (redirect) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (imem.imem_rsp_valid) begin
                    state_nxt = REQ;
                end
            end
            VALID: begin
                if (redirect) begin
                    state_nxt = REQ;
                end else if (!D_stall) begin
                    pc_en     = 1'b1;
                    consume   = 1'b1;
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output register towards decode; a flush overrides any capture or hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            F_instr       <= NOP_INSTR;
            F_instr_pc    <= 32'd0;
            F_instr_valid <= 1'b0;
        end else if (redirect) begin
            F_instr       <= NOP_INSTR;
            F_instr_valid <= 1'b0;
        end else if (capture) begin
            F_instr       <= imem.imem_rsp_data;
            F_instr_pc    <= F_pc_current;
            F_instr_valid <= 1'b1;
        end else if (consume) begin
            F_instr_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_redirects    <= '0;
        end else begin
            if ((state == VALID) && D_stall && !redirect) begin
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            end
            if (redirect) begin
                perf_redirects <= perf_redirects + 1'b1;
            end
        end
    end
`else
    assign perf_stall_cycles = '0;
    assign perf_redirects    = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, fetch, stall, redirects in WAIT/VALID, reset mid-fetch.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] F_pc_current = 32'h8000_0000;
    logic [1:0]  E_pc_src_sel = 2'b00;
    logic        D_stall = 1'b0;
    logic        pc_en;
    logic [1:0]  pc_sel;
    logic [31:0] F_instr;
    logic [31:0] F_instr_pc;
    logic        F_instr_valid;
    logic        FD_flush;
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_redirects;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_ctrl_if imem_if ();

    fetch_ctrl #(
        .NOP_INSTR (NOP),
        .CNT_WIDTH (32)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .F_pc_current      (F_pc_current),
        .E_pc_src_sel      (E_pc_src_sel),
        .D_stall           (D_stall),
        .imem              (imem_if.master),
        .pc_en             (pc_en),
        .pc_sel            (pc_sel),
        .F_instr           (F_instr),
        .F_instr_pc        (F_instr_pc),
        .F_instr_valid     (F_instr_valid),
        .FD_flush          (FD_flush),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_redirects    (perf_redirects)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        imem_if.imem_gnt       = 1'b0;
        imem_if.imem_rsp_valid = 1'b0;
        imem_if.imem_rsp_data  = 32'd0;

        // Reset values
        tick();
        tick();
        check("rst_instr", F_instr, NOP);
        check("rst_instr_pc", F_instr_pc, 32'd0);
        check("rst_valid", {31'd0, F_instr_valid}, 32'd0);
        check("rst_req", {31'd0, imem_if.imem_req}, 32'd0);
        check("rst_pc_en", {31'd0, pc_en}, 32'd0);
        check("rst_flush", {31'd0, FD_flush}, 32'd0);
        check("rst_perf_stall", perf_stall_cycles, 32'd0);

        // Test 1: IDLE -> REQ with same-cycle grant, response one cycle later
        reset = 1'b0;
        #1;
        check("idle_req", {31'd0, imem_if.imem_req}, 32'd0);
        tick();
        imem_if.imem_gnt = 1'b1;
        #1;
        check("t1_req", {31'd0, imem_if.imem_req}, 32'd1);
        check("t1_addr", imem_if.imem_addr, 32'h8000_0000);
        check("t1_pc_en_req", {31'd0, pc_en}, 32'd0);
        tick();
        imem_if.imem_gnt       = 1'b0;
        imem_if.imem_rsp_valid = 1'b1;
        imem_if.imem_rsp_data  = 32'h0050_0093;
        #1;
        check("t1_wait_req", {31'd0, imem_if.imem_req}, 32'd0);
        check("t1_wait_valid", {31'd0, F_instr_valid}, 32'd0);
        tick();
        imem_if.imem_rsp_valid = 1'b0;
        imem_if.imem_rsp_data  = 32'hFFFF_FFFF;

        // Test 2: hold D_stall for four cycles in VALID
        D_stall = 1'b1;
        #1;
        check("t1_valid", {31'd0, F_instr_valid}, 32'd1);
        check("t1_instr", F_instr, 32'h0050_0093);
        check("t1_instr_pc", F_instr_pc, 32'h8000_0000);
        for (int i = 0; i < 4; i++) begin
            check("t2_pc_en_stall", {31'd0, pc_en}, 32'd0);
            tick();
            check("t2_instr_hold", F_instr, 32'h0050_0093);
            check("t2_pc_hold", F_instr_pc, 32'h8000_0000);
        end
        D_stall = 1'b0;
        #1;
        check("t2_valid_hold", {31'd0, F_instr_valid}, 32'd1);
        check("t1_pc_en", {31'd0, pc_en}, 32'd1);
        check("t1_pc_sel", {30'd0, pc_sel}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("t2_perf_stall", perf_stall_cycles, 32'd4);
`else
        check("t2_perf_stall", perf_stall_cycles, 32'd0);
`endif
        tick();
        F_pc_current = 32'h8000_0004;

        // Reserved select 11 acts as sequential; stray response in REQ is ignored
        E_pc_src_sel           = 2'b11;
        imem_if.imem_rsp_valid = 1'b1;
        #1;
        check("sel11_flush", {31'd0, FD_flush}, 32'd0);
        check("sel11_pc_en", {31'd0, pc_en}, 32'd0);
        check("consumed_valid", {31'd0, F_instr_valid}, 32'd0);
        tick();
        E_pc_src_sel           = 2'b00;
        imem_if.imem_rsp_valid = 1'b0;
        #1;
        check("stray_rsp_req", {31'd0, imem_if.imem_req}, 32'd1);
        check("t3_addr", imem_if.imem_addr, 32'h8000_0004);

        // Test 3: branch redirect in WAIT, response arrives two cycles later
        imem_if.imem_gnt = 1'b1;
        tick();
        imem_if.imem_gnt = 1'b0;
        E_pc_src_sel     = 2'b01;
        #1;
        check("t3_flush", {31'd0, FD_flush}, 32'd1);
        check("t3_pc_en", {31'd0, pc_en}, 32'd1);
        check("t3_pc_sel", {30'd0, pc_sel}, 32'd1);
        tick();
        E_pc_src_sel = 2'b00;
        F_pc_current = 32'h8000_0100;
        #1;
        check("t3_drain_req", {31'd0, imem_if.imem_req}, 32'd0);
        tick();
        imem_if.imem_rsp_valid = 1'b1;
        imem_if.imem_rsp_data  = 32'h1234_5678;
        #1;
        check("t3_drain_valid", {31'd0, F_instr_valid}, 32'd0);
        tick();
        imem_if.imem_rsp_valid = 1'b0;
        #1;
        check("t3_discard_valid", {31'd0, F_instr_valid}, 32'd0);
        check("t3_discard_instr", F_instr, NOP);
        check("t3_new_req", {31'd0, imem_if.imem_req}, 32'd1);
        check("t3_new_addr", imem_if.imem_addr, 32'h8000_0100);

        // Test 4: jalr redirect in the same cycle as the response
        imem_if.imem_gnt = 1'b1;
        tick();
        imem_if.imem_gnt       = 1'b0;
        imem_if.imem_rsp_valid = 1'b1;
        imem_if.imem_rsp_data  = 32'hAAAA_5555;
        E_pc_src_sel           = 2'b10;
        #1;
        check("t4_pc_sel", {30'd0, pc_sel}, 32'd2);
        check("t4_flush", {31'd0, FD_flush}, 32'd1);
        tick();
        imem_if.imem_rsp_valid = 1'b0;
        E_pc_src_sel           = 2'b00;
        F_pc_current           = 32'h8000_0200;
        #1;
        check("t4_req", {31'd0, imem_if.imem_req}, 32'd1);
        check("t4_valid", {31'd0, F_instr_valid}, 32'd0);
        check("t4_instr", F_instr, NOP);
`ifdef FETCH_PERF_CNT_EN
        check("t4_perf_redir", perf_redirects, 32'd2);
`else
        check("t4_perf_redir", perf_redirects, 32'd0);
`endif

        // Test 5: redirect and D_stall together in VALID
        imem_if.imem_gnt = 1'b1;
        tick();
        imem_if.imem_gnt       = 1'b0;
        imem_if.imem_rsp_valid = 1'b1;
        imem_if.imem_rsp_data  = 32'h00A0_0113;
        tick();
        imem_if.imem_rsp_valid = 1'b0;
        D_stall                = 1'b1;
        E_pc_src_sel           = 2'b01;
        #1;
        check("t5_valid", {31'd0, F_instr_valid}, 32'd1);
        check("t5_instr", F_instr, 32'h00A0_0113);
        check("t5_instr_pc", F_instr_pc, 32'h8000_0200);
        check("t5_flush", {31'd0, FD_flush}, 32'd1);
        check("t5_pc_en", {31'd0, pc_en}, 32'd1);
        tick();
        D_stall      = 1'b0;
        E_pc_src_sel = 2'b00;
        F_pc_current = 32'h8000_0300;
        #1;
        check("t5_flushed_valid", {31'd0, F_instr_valid}, 32'd0);
        check("t5_flushed_instr", F_instr, NOP);
`ifdef FETCH_PERF_CNT_EN
        check("t5_perf_stall", perf_stall_cycles, 32'd4);
        check("t5_perf_redir", perf_redirects, 32'd3);
`endif

        // Test 6: asynchronous reset while WAIT, late response in IDLE
        imem_if.imem_gnt = 1'b1;
        tick();
        imem_if.imem_gnt = 1'b0;
        reset            = 1'b1;
        #1;
        check("t6_req", {31'd0, imem_if.imem_req}, 32'd0);
        check("t6_instr", F_instr, NOP);
        check("t6_instr_pc", F_instr_pc, 32'd0);
        check("t6_perf_redir", perf_redirects, 32'd0);
        tick();
        reset                  = 1'b0;
        imem_if.imem_rsp_valid = 1'b1;
        #1;
        check("t6_idle_req", {31'd0, imem_if.imem_req}, 32'd0);
        check("t6_idle_pc_en", {31'd0, pc_en}, 32'd0);
        tick();
        imem_if.imem_rsp_valid = 1'b0;
        #1;
        check("t6_valid", {31'd0, F_instr_valid}, 32'd0);
        check("t6_req_after", {31'd0, imem_if.imem_req}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
